// File: rtl/regm_pkg.sv
// Shared sizing, issue-request bundle and latency helper for the regm
// issue scoreboard.
package regm_pkg;

    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int LATW    = 3;
    localparam int MAX_LAT = (1 << LATW) - 1;

    // One decode slot as seen by the scheduler.
    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   src1;
        logic [AW-1:0]   src2;
        logic            wr;
        logic [AW-1:0]   dst;
        logic [LATW-1:0] lat;
    } req_t;

    // A zero latency would leave the destination looking free while the
    // producer is still in flight, so it is treated as a one-cycle op.
    function automatic logic [LATW-1:0] lat_eff(input logic [LATW-1:0] lat);
        return (lat == '0) ? LATW'(1) : lat;
    endfunction

endpackage

// File: rtl/regm_sb_entry.sv
// One scoreboard entry: countdown to writeback for a single register.
module regm_sb_entry
    import regm_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            set_a_i,
    input  logic            set_b_i,
    input  logic [LATW-1:0] lat_a_i,
    input  logic [LATW-1:0] lat_b_i,
    output logic            busy_o,
    output logic            due_o,
    output logic            ready_o,
    output logic            busy_nxt_o
);

    logic [LATW-1:0] cnt_q, cnt_d;
    logic            busy_q, due_q;

    // Next count: flush, then the younger slot, then the older slot, then countdown.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i)
            cnt_d = '0;
        else if (set_b_i)
            cnt_d = lat_b_i;
        else if (set_a_i)
            cnt_d = lat_a_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - LATW'(1);
    end

    // Count and its decoded status flags are all registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            due_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
            due_q  <= (cnt_d == LATW'(1));
        end
    end

    // A count of 1 is the writeback cycle; the write-through bypass covers it.
    assign ready_o    = (cnt_q <= LATW'(1));
    assign busy_o     = busy_q;
    assign due_o      = due_q;
    assign busy_nxt_o = (cnt_d != '0);

endmodule

// File: rtl/regm_issue_scoreboard.sv
// Dual-issue scheduler: per-register pending-write scoreboard that grants
// slot A and (in order) slot B against RAW/WAW hazards.
module regm_issue_scoreboard
    import regm_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reqA_valid,
    input  logic [AW-1:0]   reqA_src1,
    input  logic [AW-1:0]   reqA_src2,
    input  logic            reqA_wr,
    input  logic [AW-1:0]   reqA_dst,
    input  logic [LATW-1:0] reqA_lat,
    input  logic            reqB_valid,
    input  logic [AW-1:0]   reqB_src1,
    input  logic [AW-1:0]   reqB_src2,
    input  logic            reqB_wr,
    input  logic [AW-1:0]   reqB_dst,
    input  logic [LATW-1:0] reqB_lat,
    input  logic            stall,
    input  logic            flush,
    output logic            grantA,
    output logic            grantB,
    output logic [NREG-1:0] busy_vec,
    output logic [NREG-1:0] wb_due_vec,
    output logic [AW:0]     pending_cnt
);

    req_t            req_a, req_b;
    logic [NREG-1:0] rdy, busy_nxt;
    logic [LATW-1:0] lat_a, lat_b;
    logic            run_q;
    logic [AW:0]     pend_q, pend_d;
    logic            a_ok, b_ok, pair_hz;

    assign req_a = '{valid: reqA_valid, src1: reqA_src1, src2: reqA_src2,
                     wr: reqA_wr, dst: reqA_dst, lat: reqA_lat};
    assign req_b = '{valid: reqB_valid, src1: reqB_src1, src2: reqB_src2,
                     wr: reqB_wr, dst: reqB_dst, lat: reqB_lat};

    assign lat_a = lat_eff(req_a.lat);
    assign lat_b = lat_eff(req_b.lat);

    // Register 0 is hard-wired zero: always ready, never pending.
    assign rdy[0]        = 1'b1;
    assign busy_nxt[0]   = 1'b0;
    assign busy_vec[0]   = 1'b0;
    assign wb_due_vec[0] = 1'b0;

    // Read-port and destination checks against in-flight producers.
    assign a_ok = rdy[req_a.src1] & rdy[req_a.src2] & (~req_a.wr | rdy[req_a.dst]);
    assign b_ok = rdy[req_b.src1] & rdy[req_b.src2] & (~req_b.wr | rdy[req_b.dst]);

    // B cannot consume or overwrite what A produces in the same cycle.
    assign pair_hz = req_a.wr & (req_a.dst != '0) &
                     ((req_b.src1 == req_a.dst) | (req_b.src2 == req_a.dst) |
                      (req_b.wr & (req_b.dst == req_a.dst)));

    // run_q keeps grants off until the first edge after reset is released.
    assign grantA = run_q & req_a.valid & ~stall & ~flush & a_ok;
    assign grantB = grantA & req_b.valid & b_ok & ~pair_hz;

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        regm_sb_entry u_ent (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush_i    (flush),
            .set_a_i    (grantA & req_a.wr & (req_a.dst == AW'(r))),
            .set_b_i    (grantB & req_b.wr & (req_b.dst == AW'(r))),
            .lat_a_i    (lat_a),
            .lat_b_i    (lat_b),
            .busy_o     (busy_vec[r]),
            .due_o      (wb_due_vec[r]),
            .ready_o    (rdy[r]),
            .busy_nxt_o (busy_nxt[r])
        );
    end

    // Popcount of next-state busy flags so pending_cnt lines up with busy_vec.
    always_comb begin
        pend_d = '0;
        for (int r = 1; r < NREG; r++)
            pend_d = pend_d + (AW+1)'(busy_nxt[r]);
    end

    // Run enable and registered pending count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            pend_q <= '0;
        end else begin
            run_q  <= 1'b1;
            pend_q <= pend_d;
        end
    end

    assign pending_cnt = pend_q;

endmodule

// File: tb/tb_regm_issue_scoreboard.sv
// Self-checking bench for regm_issue_scoreboard: a reference model computes
// per-cycle expectations, which are queued on drive and compared on output.
module tb_regm_issue_scoreboard;
    import regm_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall = 1'b0;
    logic            flush = 1'b0;
    req_t            ra = '0;
    req_t            rb = '0;
    logic            grantA, grantB;
    logic [NREG-1:0] busy_vec, wb_due_vec;
    logic [AW:0]     pending_cnt;

    regm_issue_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reqA_valid  (ra.valid),
        .reqA_src1   (ra.src1),
        .reqA_src2   (ra.src2),
        .reqA_wr     (ra.wr),
        .reqA_dst    (ra.dst),
        .reqA_lat    (ra.lat),
        .reqB_valid  (rb.valid),
        .reqB_src1   (rb.src1),
        .reqB_src2   (rb.src2),
        .reqB_wr     (rb.wr),
        .reqB_dst    (rb.dst),
        .reqB_lat    (rb.lat),
        .stall       (stall),
        .flush       (flush),
        .grantA      (grantA),
        .grantB      (grantB),
        .busy_vec    (busy_vec),
        .wb_due_vec  (wb_due_vec),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              ga;
        bit              gb;
        logic [NREG-1:0] busy;
        logic [NREG-1:0] due;
        int              pend;
    } exp_t;

    exp_t            sbq[$];
    int              mcnt[NREG];
    bit              mrun = 1'b0;
    int              nchk = 0;
    int              nerr = 0;
    logic            obs_ga, obs_gb;
    logic [NREG-1:0] pre_due;
    req_t            nop = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input int v, input int s1, input int s2,
                                input int w, input int d, input int l);
        req_t q;
        q.valid = v[0];
        q.src1  = AW'(s1);
        q.src2  = AW'(s2);
        q.wr    = w[0];
        q.dst   = AW'(d);
        q.lat   = LATW'(l);
        return q;
    endfunction

    function automatic req_t rnd();
        return mk(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, MAX_LAT));
    endfunction

    function automatic bit mready(input int r);
        return (r == 0) || (mcnt[r] <= 1);
    endfunction

    function automatic int leff(input int l);
        return (l == 0) ? 1 : l;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) mcnt[r] = 0;
        mrun = 1'b0;
    endtask

    // One cycle: drive at negedge, queue the model's view, sample grants just
    // before the edge and registered outputs just after it.
    task automatic step(input req_t a, input req_t b, input logic st, input logic fl);
        exp_t e;
        int   nxt[NREG];
        int   ai, bi;
        @(negedge clk);
        ra = a; rb = b; stall = st; flush = fl;
        #1;
        e.ga = mrun && a.valid && !st && !fl && mready(int'(a.src1)) &&
               mready(int'(a.src2)) && (!a.wr || mready(int'(a.dst)));
        e.gb = e.ga && b.valid && mready(int'(b.src1)) && mready(int'(b.src2)) &&
               (!b.wr || mready(int'(b.dst))) &&
               !(a.wr && a.dst != 0 &&
                 (b.src1 == a.dst || b.src2 == a.dst || (b.wr && b.dst == a.dst)));
        ai = int'(a.dst);
        bi = int'(b.dst);
        e.busy = '0;
        e.due  = '0;
        e.pend = 0;
        nxt[0] = 0;
        for (int r = 1; r < NREG; r++) begin
            if (fl)                          nxt[r] = 0;
            else if (e.gb && b.wr && bi == r) nxt[r] = leff(int'(b.lat));
            else if (e.ga && a.wr && ai == r) nxt[r] = leff(int'(a.lat));
            else if (mcnt[r] > 0)            nxt[r] = mcnt[r] - 1;
            else                             nxt[r] = 0;
            e.busy[r] = (nxt[r] != 0);
            e.due[r]  = (nxt[r] == 1);
            if (nxt[r] != 0) e.pend++;
        end
        sbq.push_back(e);
        #3;
        obs_ga  = grantA;
        obs_gb  = grantB;
        pre_due = wb_due_vec;
        @(posedge clk);
        mcnt = nxt;
        mrun = 1'b1;
        #1;
        e = sbq.pop_front();
        chk("grantA", 64'(obs_ga), 64'(e.ga));
        chk("grantB", 64'(obs_gb), 64'(e.gb));
        chk("busy_vec", 64'(busy_vec), 64'(e.busy));
        chk("wb_due_vec", 64'(wb_due_vec), 64'(e.due));
        chk("pending_cnt", 64'(pending_cnt), 64'(e.pend));
    endtask

    initial begin
        model_reset();

        // Reset with a valid request in front of the scheduler.
        ra = mk(1, 1, 2, 0, 0, 1);
        #12;
        chk("rst_grantA", 64'(grantA), 64'd0);
        chk("rst_busy", 64'(busy_vec), 64'd0);
        chk("rst_pend", 64'(pending_cnt), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1 chk("rst_pre_edge_grantA", 64'(grantA), 64'd0);
        @(posedge clk);
        mrun = 1'b1;
        step(mk(1, 1, 2, 0, 0, 1), nop, 0, 0);
        chk("rst_first_grantA", 64'(obs_ga), 64'd1);

        // RAW against an in-flight producer with latency 3.
        step(mk(1, 1, 2, 1, 8, 3), nop, 0, 0);
        step(mk(1, 8, 0, 0, 0, 1), nop, 0, 0);
        chk("raw_wait1", 64'(obs_ga), 64'd0);
        step(mk(1, 8, 0, 0, 0, 1), nop, 0, 0);
        chk("raw_wait2", 64'(obs_ga), 64'd0);
        step(mk(1, 8, 0, 0, 0, 1), nop, 0, 0);
        chk("raw_go", 64'(obs_ga), 64'd1);
        chk("raw_wb_due8", 64'(pre_due[8]), 64'd1);

        // Intra-pair RAW, WAW, and an independent pair.
        step(mk(1, 1, 2, 1, 9, 2), mk(1, 9, 3, 0, 0, 1), 0, 0);
        chk("pair_raw_gA", 64'(obs_ga), 64'd1);
        chk("pair_raw_gB", 64'(obs_gb), 64'd0);
        for (int i = 0; i < 3; i++) step(nop, nop, 0, 0);
        step(mk(1, 1, 2, 1, 9, 2), mk(1, 3, 4, 1, 9, 3), 0, 0);
        chk("pair_waw_gB", 64'(obs_gb), 64'd0);
        for (int i = 0; i < 3; i++) step(nop, nop, 0, 0);
        step(mk(1, 1, 2, 1, 9, 2), mk(1, 10, 0, 1, 10, 3), 0, 0);
        chk("pair_ok_gB", 64'(obs_gb), 64'd1);
        chk("pair_ok_busy9", 64'(busy_vec[9]), 64'd1);
        chk("pair_ok_busy10", 64'(busy_vec[10]), 64'd1);
        for (int i = 0; i < 4; i++) step(nop, nop, 0, 0);

        // Register 0 never becomes pending.
        step(mk(1, 1, 2, 1, 0, 4), mk(1, 0, 0, 0, 0, 1), 0, 0);
        chk("r0_gB", 64'(obs_gb), 64'd1);
        chk("r0_busy0", 64'(busy_vec[0]), 64'd0);
        chk("r0_pend", 64'(pending_cnt), 64'd0);

        // Stall keeps countdowns running; flush clears everything.
        step(mk(1, 1, 2, 1, 8, 4), mk(1, 3, 4, 1, 12, 2), 0, 0);
        step(mk(1, 1, 2, 0, 0, 1), nop, 1, 0);
        chk("stall_gA", 64'(obs_ga), 64'd0);
        step(mk(1, 1, 2, 0, 0, 1), nop, 1, 0);
        chk("stall_r12_retired", 64'(busy_vec[12]), 64'd0);
        chk("stall_r8_busy", 64'(busy_vec[8]), 64'd1);
        step(mk(1, 1, 2, 0, 0, 1), nop, 1, 1);
        chk("flush_busy", 64'(busy_vec), 64'd0);
        chk("flush_pend", 64'(pending_cnt), 64'd0);

        // Latency 0 coerced to 1, then reissue in the writeback cycle.
        step(mk(1, 1, 2, 1, 5, 0), nop, 0, 0);
        chk("lat0_busy5", 64'(busy_vec[5]), 64'd1);
        step(mk(1, 1, 2, 1, 5, 2), nop, 0, 0);
        chk("reuse_gA", 64'(obs_ga), 64'd1);
        chk("reuse_due5", 64'(pre_due[5]), 64'd1);
        chk("reuse_busy5", 64'(busy_vec[5]), 64'd1);
        step(nop, nop, 0, 0);
        step(nop, nop, 0, 0);
        chk("reuse_retired5", 64'(busy_vec[5]), 64'd0);

        // Random traffic over a small register window.
        for (int i = 0; i < 400; i++)
            step(rnd(), rnd(), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 24) == 0));

        // Reset in the middle of traffic.
        step(mk(1, 1, 2, 1, 7, 5), nop, 0, 0);
        @(negedge clk);
        ra = mk(1, 1, 2, 0, 0, 1); rb = nop; stall = 1'b0; flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy_vec), 64'd0);
        chk("midrst_pend", 64'(pending_cnt), 64'd0);
        chk("midrst_gA", 64'(grantA), 64'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1 chk("midrst_pre_edge_gA", 64'(grantA), 64'd0);
        @(posedge clk);
        mrun = 1'b1;
        step(mk(1, 7, 0, 0, 0, 1), nop, 0, 0);
        chk("midrst_first_gA", 64'(obs_ga), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
